flip_commit_receiver: RTL

- Downstream receiver of the flip manager's spin output channel: the consumer of spin_valid / spin / spin_push_none / spin_ready.
- Each candidate is either committed or rejected:
  - Committed candidates (push_none=0) update the architectural spin state and are written back to spin memory through a valid/ready write port.
  - Rejected candidates (push_none=1) are dropped and counted.
- Detects convergence when STALL_LIMIT consecutive candidates are rejected.

---
 rtl/flip_manager_pkg.sv | 17 +
 rtl/flip_stall_counter.sv | 45 ++++
 rtl/flip_commit_receiver.sv | 213 +++++++++++++++++++++
 3 files changed

// File: rtl/flip_manager_pkg.sv
// rtl/flip_manager_pkg.sv - shared types and helpers for the flip commit receiver
// Contents:
//   state_e    receiver FSM state (IDLE / WRITE / DONE)
//   cnt_width  bit width needed to hold a saturating count of 0..max_val
package flip_manager_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WRITE = 2'd1,
        ST_DONE  = 2'd2
    } state_e;

    function automatic int cnt_width(input int max_val);
        return (max_val < 1) ? 1 : $clog2(max_val + 1);
    endfunction

endpackage

// File: rtl/flip_stall_counter.sv
// rtl/flip_stall_counter.sv - saturating counter with clear, increment and limit-hit flag
// Ports:
//   clk_i, rst_ni  clock, asynchronous active-low reset
//   clr_i          synchronous clear (wins over inc_i)
//   inc_i          increment request
//   cnt_o          current count (saturates at all ones)
//   hit_o          this increment brings the count to LIMIT (combinational)
module flip_stall_counter #(
    parameter int W     = 4,
    parameter int LIMIT = 1
) (
    input  logic         clk_i,
    input  logic         rst_ni,
    input  logic         clr_i,
    input  logic         inc_i,
    output logic [W-1:0] cnt_o,
    output logic         hit_o
);

    logic [W-1:0] cnt_q, cnt_d;
    logic [W:0]   cnt_inc;

    // One extra bit so the compare against LIMIT cannot alias on wrap.
    assign cnt_inc = {1'b0, cnt_q} + {{W{1'b0}}, 1'b1};
    assign hit_o   = inc_i && !clr_i && (cnt_inc == (W+1)'(LIMIT));
    assign cnt_o   = cnt_q;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (inc_i && !(&cnt_q)) begin
            cnt_d = cnt_inc[W-1:0];
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/flip_commit_receiver.sv
// rtl/flip_commit_receiver.sv - commits or rejects spin candidates, writes back, detects convergence
// Optional build macro LAGD_FLIP_STATS_EN adds commit_cnt_o, reject_cnt_o, stall_max_o.
// Ports:
//   clk_i, rst_ni              clock, asynchronous active-low reset
//   en_i, flush_i              acceptance enable, synchronous clear (committed spin kept)
//   init_valid_i, init_spin_i  load initial spin state (IDLE/DONE only)
//   spin_valid_i, spin_i, spin_push_none_i, spin_ready_o   candidate channel
//   wr_valid_o, wr_spin_o, wr_ready_i                      write-back channel
//   committed_spin_o, converged_o, budget_done_o, iter_cnt_o status
module flip_commit_receiver
    import flip_manager_pkg::*;
#(
    parameter int NUM_SPIN    = 256,
    parameter int STALL_LIMIT = 4,
    parameter int MAX_ITER    = 1024,
    parameter int CNT_W       = cnt_width(MAX_ITER)
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic                en_i,
    input  logic                flush_i,
    input  logic                init_valid_i,
    input  logic [NUM_SPIN-1:0] init_spin_i,
    input  logic                spin_valid_i,
    input  logic [NUM_SPIN-1:0] spin_i,
    input  logic                spin_push_none_i,
    output logic                spin_ready_o,
    output logic                wr_valid_o,
    output logic [NUM_SPIN-1:0] wr_spin_o,
    input  logic                wr_ready_i,
    output logic [NUM_SPIN-1:0] committed_spin_o,
    output logic                converged_o,
    output logic                budget_done_o,
`ifdef LAGD_FLIP_STATS_EN
    output logic [CNT_W-1:0]    commit_cnt_o,
    output logic [CNT_W-1:0]    reject_cnt_o,
    output logic [CNT_W-1:0]    stall_max_o,
`endif
    output logic [CNT_W-1:0]    iter_cnt_o
);

    localparam int STALL_W = cnt_width(STALL_LIMIT);

    state_e              state_q, state_d;
    logic [NUM_SPIN-1:0] committed_q, committed_d;
    logic [NUM_SPIN-1:0] wr_spin_q, wr_spin_d;
    logic                wr_valid_q, wr_valid_d;
    logic                conv_q, conv_d;
    logic                budget_q, budget_d;

    logic init_go, accept, commit_go, reject_go, cnt_clr;
    logic iter_hit, stall_hit;
    logic [STALL_W-1:0] unused_stall_cnt;

    // init_valid_i is ignored mid-write and always loses to flush_i.
    assign init_go   = init_valid_i && !flush_i && (state_q != ST_WRITE);
    // Gated by rst_ni so ready stays low while reset is held.
    assign spin_ready_o = rst_ni && en_i && (state_q == ST_IDLE) && !init_valid_i;
    assign accept    = spin_valid_i && spin_ready_o && !flush_i;
    assign commit_go = accept && !spin_push_none_i;
    assign reject_go = accept && spin_push_none_i;
    assign cnt_clr   = flush_i || init_go;

    flip_stall_counter #(.W(CNT_W), .LIMIT(MAX_ITER)) u_iter_cnt (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .clr_i  (cnt_clr),
        .inc_i  (accept),
        .cnt_o  (iter_cnt_o),
        .hit_o  (iter_hit)
    );

    // A commit breaks the reject run.
    flip_stall_counter #(.W(STALL_W), .LIMIT(STALL_LIMIT)) u_stall_cnt (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .clr_i  (cnt_clr || commit_go),
        .inc_i  (reject_go),
        .cnt_o  (unused_stall_cnt),
        .hit_o  (stall_hit)
    );

    always_comb begin
        state_d     = state_q;
        committed_d = committed_q;
        wr_spin_d   = wr_spin_q;
        wr_valid_d  = wr_valid_q;
        conv_d      = conv_q;
        budget_d    = budget_q;
        if (flush_i) begin
            state_d    = ST_IDLE;
            wr_valid_d = 1'b0;
            conv_d     = 1'b0;
            budget_d   = 1'b0;
        end else if (init_go) begin
            state_d     = ST_IDLE;
            committed_d = init_spin_i;
            conv_d      = 1'b0;
            budget_d    = 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (commit_go) begin
                        committed_d = spin_i;
                        wr_spin_d   = spin_i;
                        wr_valid_d  = 1'b1;
                        state_d     = ST_WRITE;
                        if (iter_hit) budget_d = 1'b1;
                    end else if (reject_go) begin
                        if (stall_hit) conv_d = 1'b1;
                        if (iter_hit) budget_d = 1'b1;
                        if (stall_hit || iter_hit) state_d = ST_DONE;
                    end
                end
                ST_WRITE: begin
                    // A budget-ending commit only retires once its write lands.
                    if (wr_ready_i) begin
                        wr_valid_d = 1'b0;
                        state_d    = budget_q ? ST_DONE : ST_IDLE;
                    end
                end
                ST_DONE: begin
                end
                default: begin
                    state_d    = ST_IDLE;
                    wr_valid_d = 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= ST_IDLE;
            committed_q <= '0;
            wr_spin_q   <= '0;
            wr_valid_q  <= 1'b0;
            conv_q      <= 1'b0;
            budget_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            committed_q <= committed_d;
            wr_spin_q   <= wr_spin_d;
            wr_valid_q  <= wr_valid_d;
            conv_q      <= conv_d;
            budget_q    <= budget_d;
        end
    end

    assign committed_spin_o = committed_q;
    assign wr_spin_o        = wr_spin_q;
    assign wr_valid_o       = wr_valid_q;
    assign converged_o      = conv_q;
    assign budget_done_o    = budget_q;

`ifdef LAGD_FLIP_STATS_EN
    localparam int CNT_MAX = (1 << CNT_W) - 1;

    logic             unused_commit_hit, unused_reject_hit, unused_run_hit;
    logic [CNT_W-1:0] run_cnt, run_next;
    logic [CNT_W-1:0] stall_max_q, stall_max_d;

    flip_stall_counter #(.W(CNT_W), .LIMIT(CNT_MAX)) u_commit_cnt (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .clr_i  (cnt_clr),
        .inc_i  (commit_go),
        .cnt_o  (commit_cnt_o),
        .hit_o  (unused_commit_hit)
    );

    flip_stall_counter #(.W(CNT_W), .LIMIT(CNT_MAX)) u_reject_cnt (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .clr_i  (cnt_clr),
        .inc_i  (reject_go),
        .cnt_o  (reject_cnt_o),
        .hit_o  (unused_reject_hit)
    );

    // Full-width copy of the reject run so the maximum is not limited to STALL_W.
    flip_stall_counter #(.W(CNT_W), .LIMIT(CNT_MAX)) u_run_cnt (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .clr_i  (cnt_clr || commit_go),
        .inc_i  (reject_go),
        .cnt_o  (run_cnt),
        .hit_o  (unused_run_hit)
    );

    assign run_next = (&run_cnt) ? run_cnt : run_cnt + {{(CNT_W-1){1'b0}}, 1'b1};

    always_comb begin
        stall_max_d = stall_max_q;
        if (cnt_clr) begin
            stall_max_d = '0;
        end else if (reject_go && (run_next > stall_max_q)) begin
            stall_max_d = run_next;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            stall_max_q <= '0;
        end else begin
            stall_max_q <= stall_max_d;
        end
    end

    assign stall_max_o = stall_max_q;
`endif

endmodule
